// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Last-owner pointer starts at 7 so requester 0 scans first after reset.
    localparam logic [IDX_W-1:0] LAST_PTR_RST = 3'd7;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Latency: n/a (wiring only).
// Backpressure: owner_release / request drop end a tenure; no other flow control.
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    // "release" is a reserved word, hence owner_release.
    logic             owner_release;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, owner_release,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, owner_release,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_8_enc.sv
// Combinational 8-to-3 one-hot encoder.
// Latency: 0 cycles.
// Backpressure: none.
module onehot8_to_idx
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // OR of the indices of set bits; exact for one-hot, 0 for all-zero.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter, registered one-hot grant + index; `ARB_TIMEOUT_EN adds a MAX_HOLD tenure limit.
// Latency: 1 cycle request-to-grant; one mandatory idle cycle between tenures.
// Backpressure: grant held until owner_release, owner request drop, or (optional) timeout.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_8_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 2..255");
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0] enc_idx;
    logic             force_rel;
    logic             owner_req;
    logic             rel_cond;

    // Round-robin pick: rotate so last_ptr+1 sits at bit 0, take lowest set bit, rotate back.
    logic [IDX_W-1:0]   scan_start;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   pick_rot;
    logic [2*N_REQ-1:0] pick_dbl;
    logic [N_REQ-1:0]   pick;

    assign scan_start = last_ptr_q + 3'd1;
    assign req_dbl    = {bus.req, bus.req};
    assign req_rot    = N_REQ'(req_dbl >> scan_start);
    assign pick_rot   = req_rot & (~req_rot + 8'd1);
    assign pick_dbl   = {pick_rot, pick_rot} << scan_start;
    assign pick       = pick_dbl[2*N_REQ-1:N_REQ];

    assign owner_req = bus.req[idx_q];
    assign rel_cond  = bus.owner_release | ~owner_req | force_rel;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d    = pick;
                    last_ptr_d = enc_idx;
                    idx_d      = enc_idx;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Index keeps naming the last owner after the grant drops.
                if (rel_cond) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    onehot8_to_idx u_enc (
        .onehot (pick),
        .idx    (enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            last_ptr_q <= LAST_PTR_RST;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            last_ptr_q <= last_ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    assign force_rel = (state_q == ST_BUSY) && (hold_cnt_q == 8'(MAX_HOLD - 1));

    // Counter sits at zero while idle, so each tenure starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == ST_BUSY && !rel_cond) begin
                hold_cnt_q <= hold_cnt_q + 8'd1;
            end else begin
                hold_cnt_q <= '0;
            end
            timeout_q <= force_rel & ~bus.owner_release & owner_req;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = |grant_q;

endmodule
